lfsr_prng: RTL and testbench

Free-running maximal-length pseudo-random number generator built as a Fibonacci LFSR. It supplies a fresh DATA_WIDTH-bit random word every clock. The Bernoulli spike generator compares this word against per-neuron probability thresholds to emit spikes.

---
 rtl/lfsr_prng_pkg.sv | 49 ++++
 rtl/lfsr_prng_if.sv | 9 +
 rtl/lfsr_prng.sv | 53 +++++
 tb/tb_lfsr_prng.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/lfsr_prng_pkg.sv
// Shared constants for the Fibonacci LFSR PRNG: width limits and the
// maximal-length tap table (one mask per width, bit tap-1 set).
package lfsr_prng_pkg;

    localparam int MIN_WIDTH = 3;
    localparam int MAX_WIDTH = 32;

    // Index is the register width; each mask is XOR-feedback maximal-length.
    localparam logic [31:0] TAP_TABLE [MIN_WIDTH:MAX_WIDTH] = '{
        32'h0000_0006,  // 3:  3,2
        32'h0000_000C,  // 4:  4,3
        32'h0000_0014,  // 5:  5,3
        32'h0000_0030,  // 6:  6,5
        32'h0000_0060,  // 7:  7,6
        32'h0000_00B8,  // 8:  8,6,5,4
        32'h0000_0110,  // 9:  9,5
        32'h0000_0240,  // 10: 10,7
        32'h0000_0500,  // 11: 11,9
        32'h0000_0829,  // 12: 12,6,4,1
        32'h0000_100D,  // 13: 13,4,3,1
        32'h0000_2015,  // 14: 14,5,3,1
        32'h0000_6000,  // 15: 15,14
        32'h0000_D008,  // 16: 16,15,13,4
        32'h0001_2000,  // 17: 17,14
        32'h0002_0400,  // 18: 18,11
        32'h0004_0023,  // 19: 19,6,2,1
        32'h0009_0000,  // 20: 20,17
        32'h0014_0000,  // 21: 21,19
        32'h0030_0000,  // 22: 22,21
        32'h0042_0000,  // 23: 23,18
        32'h00E1_0000,  // 24: 24,23,22,17
        32'h0120_0000,  // 25: 25,22
        32'h0200_0023,  // 26: 26,6,2,1
        32'h0400_0013,  // 27: 27,5,2,1
        32'h0900_0000,  // 28: 28,25
        32'h1400_0000,  // 29: 29,27
        32'h2000_0029,  // 30: 30,6,4,1
        32'h4800_0000,  // 31: 31,28
        32'h8020_0003   // 32: 32,22,2,1
    };

    function automatic logic [31:0] taps_for(input int width);
        if (width < MIN_WIDTH || width > MAX_WIDTH) begin
            return '0;
        end
        return TAP_TABLE[width];
    endfunction

endpackage

// File: rtl/lfsr_prng_if.sv
// Output bundle of the LFSR PRNG: one random word per clock, no handshake.
interface lfsr_prng_if #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] dout;

    modport master (output dout);
    modport slave  (input  dout);
endinterface

// File: rtl/lfsr_prng.sv
// Free-running maximal-length Fibonacci LFSR; dout is the state register.
// Optional all-zero state recovery: LFSR_PRNG_LOCKUP_RECOVERY_EN.
module lfsr_prng
    import lfsr_prng_pkg::*;
#(
    parameter int          DATA_WIDTH = 32,
    parameter logic [31:0] SEED       = 32'd1
) (
    input  logic         clk,
    input  logic         rst,
    lfsr_prng_if.master  prng_o
);

    if (DATA_WIDTH < MIN_WIDTH || DATA_WIDTH > MAX_WIDTH) begin : g_width_check
        $error("lfsr_prng: DATA_WIDTH %0d outside legal range %0d..%0d",
               DATA_WIDTH, MIN_WIDTH, MAX_WIDTH);
    end

    localparam logic [31:0]           TAP_MASK = taps_for(DATA_WIDTH);
    localparam logic [DATA_WIDTH-1:0] TAPS_W   = TAP_MASK[DATA_WIDTH-1:0];
    localparam logic [DATA_WIDTH-1:0] SEED_W   = SEED[DATA_WIDTH-1:0];

    logic [DATA_WIDTH-1:0] q_q;
    logic [DATA_WIDTH-1:0] q_d;
    logic                  fb;

`ifdef LFSR_PRNG_LOCKUP_RECOVERY_EN
    // A zero seed would re-lock immediately, so recovery falls back to 1.
    localparam logic [DATA_WIDTH-1:0] RECOVER_W =
        (SEED_W == '0) ? DATA_WIDTH'(1) : SEED_W;
`endif

    always_comb begin
        fb  = ^(q_q & TAPS_W);
        q_d = {q_q[DATA_WIDTH-2:0], fb};
`ifdef LFSR_PRNG_LOCKUP_RECOVERY_EN
        if (q_q == '0) begin
            q_d = RECOVER_W;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q <= SEED_W;
        end else begin
            q_q <= q_d;
        end
    end

    assign prng_o.dout = q_q;

endmodule

// File: tb/tb_lfsr_prng.sv
// Scoreboard bench for lfsr_prng: 32-bit seed 1, 8-bit seed 1 and 8-bit seed 0
// instances checked every cycle against a tap-list reference model.
`timescale 1ns/1ps
module tb_lfsr_prng;

    logic clk;
    logic clk_en;
    logic rst;

    lfsr_prng_if #(.DATA_WIDTH(32)) if32 ();
    lfsr_prng_if #(.DATA_WIDTH(8))  if8 ();
    lfsr_prng_if #(.DATA_WIDTH(8))  if8z ();

    lfsr_prng #(.DATA_WIDTH(32), .SEED(32'd1)) dut32 (.clk(clk), .rst(rst), .prng_o(if32));
    lfsr_prng #(.DATA_WIDTH(8),  .SEED(32'd1)) dut8  (.clk(clk), .rst(rst), .prng_o(if8));
    lfsr_prng #(.DATA_WIDTH(8),  .SEED(32'd0)) dut8z (.clk(clk), .rst(rst), .prng_o(if8z));

    typedef struct {
        int          step;
        logic [31:0] e32;
        logic [7:0]  e8;
        logic [7:0]  e8z;
    } exp_t;

    exp_t        sb_q[$];
    int          checks = 0;
    int          errors = 0;
    bit          mon_en = 0;
    bit          track8 = 0;
    int          seen8 [256];
    int          step_no = 0;
    logic [31:0] m32, m8, m8z;

    initial begin
        clk = 1'b0;
        forever begin
            #5;
            if (clk_en) clk = ~clk;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %h expected %h", name, step_no, act, exp);
        end
    endtask

    // Reference: shift left, new bit 0 = XOR of the listed 1-indexed taps.
    function automatic logic [31:0] ref_next(input logic [31:0] s, input int w,
                                             input logic [31:0] seed);
        int     taps[$];
        logic   fb;
        longint nxt;
        if (w == 32) taps = '{32, 22, 2, 1};
        else         taps = '{8, 6, 5, 4};
`ifdef LFSR_PRNG_LOCKUP_RECOVERY_EN
        if (s == 0) return (seed == 0) ? 32'd1 : seed;
`endif
        fb = 1'b0;
        foreach (taps[i]) fb ^= s[taps[i]-1];
        nxt = (longint'(s) << 1) | longint'(fb);
        nxt = nxt & ((longint'(1) << w) - 1);
        return nxt[31:0];
    endfunction

    task automatic model_reset();
        m32 = 32'd1;
        m8  = 32'd1;
        m8z = 32'd0;
    endtask

    task automatic step_n(input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            step_no++;
            m32 = ref_next(m32, 32, 32'd1);
            m8  = ref_next(m8,  8,  32'd1);
            m8z = ref_next(m8z, 8,  32'd0);
            e.step = step_no;
            e.e32  = m32;
            e.e8   = m8[7:0];
            e.e8z  = m8z[7:0];
            sb_q.push_back(e);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            if (sb_q.size() == 0) begin
                chk("scoreboard_underflow", 32'd1, 32'd0);
            end else begin
                e = sb_q.pop_front();
                chk("dout32",  if32.dout,         e.e32);
                chk("dout8",   {24'd0, if8.dout},  {24'd0, e.e8});
                chk("dout8z",  {24'd0, if8z.dout}, {24'd0, e.e8z});
                if (track8) seen8[if8.dout]++;
            end
        end
    end

    // Asynchronous reset pulse in the low phase, checked before any edge.
    task automatic reset_pulse(input int dly);
        @(negedge clk);
        #(dly);
        rst = 1'b1;
        #1;
        model_reset();
        chk("async_rst32", if32.dout,        m32);
        chk("async_rst8",  {24'd0, if8.dout},  m8);
        chk("async_rst8z", {24'd0, if8z.dout}, m8z);
        #1;
        rst = 1'b0;
        step_no = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int distinct;
        clk_en = 1'b0;
        rst    = 1'b1;
        foreach (seen8[i]) seen8[i] = 0;
        model_reset();
        #5;
        chk("reset32",  if32.dout,         32'h0000_0001);
        chk("reset8",   {24'd0, if8.dout},  32'h0000_0001);
        chk("reset8z",  {24'd0, if8z.dout}, 32'h0000_0000);

        rst    = 1'b0;
        #2;
        mon_en = 1'b1;
        track8 = 1'b1;
        clk_en = 1'b1;
        step_n(255);
        @(negedge clk);
        #1;
        track8 = 1'b0;
        chk("period8_return", {24'd0, if8.dout}, 32'h0000_0001);
        distinct = 0;
        for (int v = 1; v < 256; v++) if (seen8[v] == 1) distinct++;
        chk("period8_distinct", distinct, 255);
        chk("period8_no_zero",  seen8[0], 0);

        step_n(10);
        reset_pulse(2);
        step_n(1);
        @(negedge clk);
        #1;
        chk("restart32", if32.dout, 32'h0000_0003);
        step_n(3);

        for (int r = 0; r < 4; r++) begin
            step_n($urandom_range(1, 60));
            reset_pulse($urandom_range(1, 2));
            step_n($urandom_range(20, 40));
        end

        @(negedge clk);
        #1;
        mon_en = 1'b0;
        chk("scoreboard_drained", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
